uart_tx: RTL and testbench
==========================

# uart_tx

Byte-serial UART transmitter for the return path of the transceiver. It takes each corrected byte from the decoder's 8-bit output and its `data_valid` strobe, and serializes it onto the `q` line. The format is one start bit, 8 data bits LSB first and one stop bit, each bit held for `CLKS_PER_BIT` clocks. A one-entry holding buffer lets the decoder hand over the next byte while the current frame is still shifting, so consecutive frames go out with no idle gap.

## Interface
- `CLKS_PER_BIT`, default 4: clocks per serial bit. Legal range is ≥ 2.
- `DATA_W`, default 8: data bits per frame.
- `clk` in, 1: system clock. All logic is on the rising edge.
- `rst` in, 1: synchronous, active-low reset.
- `en` in, 1: transmitter enable. It gates byte acceptance and frame start.
- `data_valid` in, 1: single-cycle strobe marking `data_in` as valid.
- `data_in` in, `DATA_W`: byte to send, normally the decoder output.
- `ready` out, 1: holding buffer empty. Equals `!hold_full` (combinational).
- `q` out, 1: serial line, registered. Idles high.
- `active` out, 1: high while a frame (start, data or stop bit) is on `q`.
- `done` out, 1: one-cycle pulse at the end of each stop bit.
- `overrun` out, 1: sticky flag, set when a byte is dropped.

## Operation
- **Reset** (`rst`=0 at an edge):
  - State → IDLE.
  - `q`=1, `active`=0, `done`=0, `overrun`=0.
  - `hold_full`=0, so `ready`=1.
  - Bit counter and clock counter → 0.
- **Accept:** at an edge with `en`=1, `data_valid`=1 and `ready`=1:
  - `hold` ← `data_in`;
  - `hold_full` ← 1.
- **Drop:** `data_valid`=1 with `ready`=0 sets `overrun`=1. The byte is discarded and `hold` is unchanged. `overrun` clears only on reset.
- **Disabled input:** `data_valid`=1 with `en`=0 is ignored and does not set `overrun`.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** `q`=1, `active`=0. If `hold_full`=1 and `en`=1, then at the next edge:
    - shift register ← `hold`;
    - `hold_full` ← 0;
    - state → START.
  - **START:** `q`=0 for `CLKS_PER_BIT` clocks, then → DATA with bit index 0.
  - **DATA:** `q`=`shift[0]` for `CLKS_PER_BIT` clocks, then shift right. After bit `DATA_W-1` → STOP.
  - **STOP:** `q`=1 for `CLKS_PER_BIT` clocks. On the final clock of the stop bit:
    - `done` pulses;
    - if `hold_full`=1 and `en`=1, load from `hold` and go directly to START (back-to-back, `active` stays 1);
    - otherwise → IDLE.
- **Same-edge load and accept:** when a load from `hold` and an accept fall on the same edge, both happen. The FSM takes the old byte and `hold` takes the new one, so `hold_full` stays 1.
- **`en` deasserted mid-frame:** the current frame still completes. A byte already held stays held until `en` returns to 1.
- **Reset mid-frame:** the frame is aborted and the held byte is lost. `q` returns to 1 on the next edge.
- **Counter widths:**
  - clock counter: `$clog2(CLKS_PER_BIT)` bits, wraps at `CLKS_PER_BIT-1`;
  - bit index: `$clog2(DATA_W)` bits.

## Timing
- **Frame length:** `(DATA_W+2)*CLKS_PER_BIT` clocks. This is 40 clocks at the defaults.
- **Latency:** with a byte accepted at edge N while IDLE:
  - `hold_full`=1 after edge N;
  - START is entered at edge N+1, so `q` falls one clock after acceptance;
  - `ready` is 0 for exactly one cycle.
- **Bit boundaries:** `q` changes only on bit boundaries, every `CLKS_PER_BIT` edges after START entry.
- **`done`:** high for exactly one cycle, at the final clock of STOP (same cycle as `q`'s last stop-bit clock). It is 0 at all other times.
- **Back-to-back frames:** the next start bit follows the previous stop bit directly, with zero idle clocks.
- **Sustained throughput:** one byte per frame length. A second byte offered before `hold` drains sets `overrun`.

## Test plan
1. **Reset values.** Hold `rst`=0 for 3 clocks, then release. Require `q`=1, `active`=0, `done`=0, `ready`=1, `overrun`=0 throughout and after release.
2. **Single frame.** Send 0xA5 at the defaults with `en`=1. Require:
   - `q` follows 0,1,0,1,0,0,1,0,1,1, each value for 4 clocks;
   - `q` falls 1 clock after acceptance;
   - `done` pulses once, 40 clocks after START entry;
   - `active` is high for exactly 40 clocks.
3. **Back-to-back.** Send 0x00, then 0xFF 2 clocks later. Require:
   - 80 contiguous active clocks with no high gap between the first stop bit and the second start bit;
   - two `done` pulses, 40 clocks apart;
   - `overrun`=0.
4. **Overrun.** While a frame is shifting and `hold` is full, pulse `data_valid` with 0x3C. Require `overrun`=1 (sticky), the held byte transmitted unchanged, and no 0x3C on `q`.
5. **Enable gating.** With `en`=0, pulse `data_valid` with 0x55: nothing is accepted and `q` stays 1. Then:
   - with `en`=1, accept 0x55, and drop `en` mid-frame: the frame completes;
   - accept 0x81 during the frame, then wait 10 clocks after its stop bit with `en`=0: `q`=1 and `hold` is retained;
   - raise `en` again: 0x81 starts 1 clock later.
6. **Reset mid-frame.** Assert `rst` during DATA bit 3. Require `q`=1, `active`=0 and `ready`=1 after the edge, and no `done` pulse.

Source files
------------

// File: rtl/uart_tx.sv
// Byte-serial UART transmitter: start bit, DATA_W data bits LSB first, stop bit.
// A one-entry holding buffer allows back-to-back frames with no idle gap.
module uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              q,
  output logic              active,
  output logic              done,
  output logic              overrun,
  output logic [1:0]        state_dbg
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state;
  logic [CW-1:0]     clk_cnt;
  logic [BW-1:0]     bit_idx;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] hold;
  logic              hold_full;
  logic              bit_end;
  logic              accept;
  logic              drop;
  logic              load;

  // Handshake: a byte is taken on any edge where en && data_valid && ready;
  // data_valid while ready is low (and en high) loses the byte and flags overrun.
  always_comb begin
    bit_end   = (clk_cnt == CNT_LAST);
    accept    = en && data_valid && !hold_full;
    drop      = en && data_valid && hold_full;
    load      = hold_full && en && ((state == IDLE) || ((state == STOP) && bit_end));
    ready     = !hold_full;
    state_dbg = state;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      q         <= 1'b1;
      active    <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      hold_full <= 1'b0;
      hold      <= '0;
      shift     <= '0;
      clk_cnt   <= '0;
      bit_idx   <= '0;
    end else begin
      done <= 1'b0;
      if (drop) overrun <= 1'b1;
      // A same-edge accept wins over the load so the new byte stays held.
      if (accept) begin
        hold      <= data_in;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          q       <= 1'b1;
          active  <= 1'b0;
          clk_cnt <= '0;
          if (load) begin
            shift  <= hold;
            state  <= START;
            q      <= 1'b0;
            active <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
            q       <= shift[0];
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              state <= STOP;
              q     <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift >> 1;
              q       <= shift[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          // done is registered, so it is raised one clock ahead of the final stop clock.
          if (clk_cnt == CNT_PRE) done <= 1'b1;
          if (bit_end) begin
            clk_cnt <= '0;
            if (load) begin
              shift <= hold;
              state <= START;
              q     <= 1'b0;
            end else begin
              state  <= IDLE;
              active <= 1'b0;
              q      <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4, DATA_W=8: reset, single frame,
// back-to-back, overrun, enable gating and mid-frame reset.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       data_valid;
  logic [7:0] data_in;
  logic       ready;
  logic       q;
  logic       active;
  logic       done;
  logic       overrun;
  logic [1:0] state_dbg;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .CLKS_PER_BIT(4),
    .DATA_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .data_valid(data_valid),
    .data_in   (data_in),
    .ready     (ready),
    .q         (q),
    .active    (active),
    .done      (done),
    .overrun   (overrun),
    .state_dbg (state_dbg)
  );

  // Outputs are sampled and inputs driven 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_ready);
    chk({tag, ".q"}, q, 1'b1);
    chk({tag, ".active"}, active, 1'b0);
    chk({tag, ".done"}, done, 1'b0);
    chk({tag, ".ready"}, ready, exp_ready);
  endtask

  // Called in the cycle right after START entry; checks all 40 frame clocks.
  // Optional events: en dropped at drop_at, byte strobes at a_at/b_at (en forced
  // high for that one edge, then restored).
  task automatic check_frame(input logic [7:0] b, input int drop_at,
                             input int a_at, input logic [7:0] a_dat,
                             input int b_at, input logic [7:0] b_dat);
    logic [9:0] frame;
    logic       en_save;
    logic       injected;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("frm%02h.q[%0d]", b, i), q, frame[i/4]);
      chk($sformatf("frm%02h.active[%0d]", b, i), active, 1'b1);
      chk($sformatf("frm%02h.done[%0d]", b, i), done, (i == 39));
      if (i == drop_at) en = 1'b0;
      injected = 1'b0;
      en_save  = en;
      if (i == a_at) begin
        en = 1'b1; data_valid = 1'b1; data_in = a_dat; injected = 1'b1;
      end else if (i == b_at) begin
        en = 1'b1; data_valid = 1'b1; data_in = b_dat; injected = 1'b1;
      end
      tick();
      data_valid = 1'b0;
      if (injected) en = en_save;
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; data_valid = 1'b0; data_in = 8'h00;

    // Reset values
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle($sformatf("rst%0d", i), 1'b1);
      chk($sformatf("rst%0d.overrun", i), overrun, 1'b0);
    end
    rst = 1'b1;
    tick();
    chk_idle("rel", 1'b1);
    chk("rel.overrun", overrun, 1'b0);

    // Single frame 0xA5
    en = 1'b1; data_valid = 1'b1; data_in = 8'hA5;
    tick();
    data_valid = 1'b0;
    chk_idle("a5.acc", 1'b0);
    tick();
    chk("a5.start.ready", ready, 1'b1);
    check_frame(8'hA5, -1, -1, 8'h00, -1, 8'h00);
    chk_idle("a5.end", 1'b1);

    // Back-to-back 0x00 then 0xFF offered two clocks after acceptance
    data_valid = 1'b1; data_in = 8'h00;
    tick();
    data_valid = 1'b0;
    tick();
    check_frame(8'h00, -1, 0, 8'hFF, -1, 8'h00);
    check_frame(8'hFF, -1, -1, 8'h00, -1, 8'h00);
    chk_idle("b2b.end", 1'b1);
    chk("b2b.overrun", overrun, 1'b0);

    // Overrun: hold 0x6B, then 0x3C arrives while hold is full
    data_valid = 1'b1; data_in = 8'h12;
    tick();
    data_valid = 1'b0;
    tick();
    check_frame(8'h12, -1, 0, 8'h6B, 20, 8'h3C);
    chk("ovr.set", overrun, 1'b1);
    check_frame(8'h6B, -1, -1, 8'h00, -1, 8'h00);
    chk_idle("ovr.end", 1'b1);
    chk("ovr.sticky", overrun, 1'b1);

    // Enable gating
    en = 1'b0; data_valid = 1'b1; data_in = 8'h55;
    tick();
    data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle($sformatf("dis%0d", i), 1'b1);
    end
    en = 1'b1; data_valid = 1'b1; data_in = 8'h55;
    tick();
    data_valid = 1'b0;
    tick();
    check_frame(8'h55, 6, 20, 8'h81, -1, 8'h00);
    chk("gate.en", en, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk_idle($sformatf("held%0d", i), 1'b0);
      tick();
    end
    en = 1'b1;
    tick();
    chk("resume.q", q, 1'b0);
    chk("resume.ready", ready, 1'b1);
    check_frame(8'h81, -1, -1, 8'h00, -1, 8'h00);
    chk_idle("resume.end", 1'b1);

    // Reset during DATA bit 3, with a byte waiting in hold
    data_valid = 1'b1; data_in = 8'hF0;
    tick();
    data_valid = 1'b0;
    tick();
    data_valid = 1'b1; data_in = 8'h77;
    tick();
    data_valid = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    chk("mid.active", active, 1'b1);
    chk("mid.q", q, 1'b0);
    rst = 1'b0;
    tick();
    chk_idle("mrst", 1'b1);
    chk("mrst.overrun", overrun, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 45; i++) begin
      tick();
      chk($sformatf("post%0d.done", i), done, 1'b0);
      chk($sformatf("post%0d.active", i), active, 1'b0);
      chk($sformatf("post%0d.q", i), q, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
